// File: rtl/control_unit_if.sv
// +-------------------------------------------------------------------+
// | k_and_s_pkg / control_unit_if                                     |
// | Opcode type and the control/status bundle between control_unit    |
// | and data_path.                                                    |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
`default_nettype none

package k_and_s_pkg;
  // Encodings 14 and 15 are unassigned and decode as NOP.
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic       zero_op;
  logic       neg_op;
  logic       unsigned_overflow;
  logic       signed_overflow;

  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       write_reg_enable;
  logic       flags_reg_enable;
  logic       ram_write_enable;
  logic       halted;
  logic [3:0] cond_flags;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halted, cond_flags
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halted, cond_flags
  );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// +-------------------------------------------------------------------+
// | control_unit                                                      |
// | Fetch/decode/execute sequencer driving the data_path controls.    |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
`default_nettype none

module control_unit
  import k_and_s_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst_n,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXEC_LOAD  = 3'd2,
    S_EXEC_STORE = 3'd3,
    S_EXEC_ALU   = 3'd4,
    S_EXEC_BR    = 3'd5,
    S_HALT       = 3'd6
  } state_t;

  state_t     r_state;
  logic [3:0] r_cond_flags;
  logic       r_flag_pending;
  logic       w_take;

  always_comb begin
    w_take = 1'b0;
    case (bus.decoded_instruction)
      I_BRANCH: w_take = 1'b1;
      I_BZERO:  w_take = r_cond_flags[0];
      I_BNZERO: w_take = ~r_cond_flags[0];
      I_BNEG:   w_take = r_cond_flags[1];
      I_BNNEG:  w_take = ~r_cond_flags[1];
      default:  w_take = 1'b0;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted EXEC cycle writes nothing.
  always_comb begin
    bus.branch           = 1'b0;
    bus.pc_enable        = 1'b0;
    bus.ir_enable        = 1'b0;
    bus.addr_sel         = 1'b0;
    bus.c_sel            = 1'b0;
    bus.operation        = 2'b00;
    bus.write_reg_enable = 1'b0;
    bus.flags_reg_enable = 1'b0;
    bus.ram_write_enable = 1'b0;
    bus.halted           = 1'b0;
    bus.cond_flags       = rst_n ? r_cond_flags : 4'b0000;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          bus.addr_sel  = 1'b1;
          bus.ir_enable = 1'b1;
          bus.pc_enable = 1'b1;
        end
        S_EXEC_LOAD: begin
          bus.c_sel            = 1'b1;
          bus.write_reg_enable = 1'b1;
        end
        S_EXEC_STORE: bus.ram_write_enable = 1'b1;
        S_EXEC_ALU: begin
          bus.write_reg_enable = 1'b1;
          case (bus.decoded_instruction)
            I_ADD: begin bus.operation = 2'b01; bus.flags_reg_enable = 1'b1; end
            I_SUB: begin bus.operation = 2'b10; bus.flags_reg_enable = 1'b1; end
            I_AND: begin bus.operation = 2'b11; bus.flags_reg_enable = 1'b1; end
            I_OR:  begin bus.operation = 2'b00; bus.flags_reg_enable = 1'b1; end
            default: bus.operation = 2'b00;
          endcase
        end
        S_EXEC_BR: begin
          bus.branch    = w_take;
          bus.pc_enable = w_take;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_FETCH;
      r_cond_flags   <= 4'b0000;
      r_flag_pending <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // The data_path flag register was loaded at the end of EXEC_ALU.
          if (r_flag_pending) begin
            r_cond_flags   <= {bus.signed_overflow, bus.unsigned_overflow,
                               bus.neg_op, bus.zero_op};
            r_flag_pending <= 1'b0;
          end
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (bus.decoded_instruction)
            I_LOAD:  r_state <= S_EXEC_LOAD;
            I_STORE: r_state <= S_EXEC_STORE;
            I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
                     r_state <= S_EXEC_ALU;
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG:
                     r_state <= S_EXEC_BR;
            I_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH;
          endcase
        end
        S_EXEC_ALU: begin
          if (bus.decoded_instruction != I_MOVE)
            r_flag_pending <= 1'b1;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Instruction-sequencing FSM for the K&S 16-bit processor. Consumes `decoded_instruction` and the registered ALU flags from `data_path` and drives every `data_path` control input plus the RAM write strobe. It is the control side of the `data_path` control/status interface, and sits beside `data_path` inside the processor top level. It runs a fetch/decode/execute cycle over a 32-word RAM with asynchronous read and synchronous write.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `decoded_instruction`  in  `decoded_instruction_type` (k_and_s_pkg)  current IR opcode.
- `zero_op`, `neg_op`  in  1 each  registered zero/negative flags from `data_path`.
- `unsigned_overflow`, `signed_overflow`  in  1 each  registered overflow flags.
- `branch`  out  1  PC mux: 1 selects the target address, 0 selects PC+1.
- `pc_enable`  out  1  PC load.
- `ir_enable`  out  1  IR load.
- `addr_sel`  out  1  RAM address: 1 selects PC, 0 selects the instruction address field.
- `c_sel`  out  1  bus C: 1 selects RAM `data_in`, 0 selects the ALU.
- `operation`  out  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND.
- `write_reg_enable`  out  1  register-file write.
- `flags_reg_enable`  out  1  flag-register load.
- `ram_write_enable`  out  1  RAM write strobe; the write occurs at the clock edge.
- `halted`  out  1  processor stopped.
- `cond_flags`  out  4  held copy of {signed_ovf, unsigned_ovf, neg, zero}.

## Operation
- **States**: FETCH, DECODE, EXEC_LOAD, EXEC_STORE, EXEC_ALU, EXEC_BR, HALT.
- **Reset**:
  - While `rst_n`=0, all outputs are combinationally 0.
  - At a clock edge with `rst_n`=0, the state becomes FETCH, `cond_flags` clears to 0 and `flag_pending` clears to 0.
- **FETCH**:
  - Drives `addr_sel`=1, `ir_enable`=1, `pc_enable`=1, `branch`=0. The IR captures `RAM[PC]` and PC becomes PC+1.
  - Next state: DECODE.
- **DECODE**: all enables 0. Next state by opcode:
  - NOP → FETCH.
  - LOAD → EXEC_LOAD.
  - STORE → EXEC_STORE.
  - MOVE, ADD, SUB, AND, OR → EXEC_ALU.
  - BRANCH, BZERO, BNZERO, BNEG, BNNEG → EXEC_BR.
  - HALT → HALT.
  - Any other encoding → FETCH (treated as NOP).
- **EXEC_LOAD**: `addr_sel`=0, `c_sel`=1, `write_reg_enable`=1. Next state: FETCH.
- **EXEC_STORE**: `addr_sel`=0, `ram_write_enable`=1. Next state: FETCH.
- **EXEC_ALU**:
  - Drives `c_sel`=0 and `write_reg_enable`=1.
  - `operation` by opcode: ADD=01, SUB=10, AND=11, OR=00, MOVE=00 (A|A).
  - `flags_reg_enable`=1 for ADD/SUB/AND/OR and 0 for MOVE.
  - For ADD/SUB/AND/OR, set `flag_pending`=1.
  - Next state: FETCH.
- **Flag capture**:
  - Applies in a FETCH cycle with `flag_pending`=1.
  - `cond_flags` <= {`signed_overflow`, `unsigned_overflow`, `neg_op`, `zero_op`}, and `flag_pending` clears.
  - Flags are captured exactly once per flag-setting instruction. `cond_flags` holds otherwise; MOVE, LOAD and STORE leave it unchanged.
- **EXEC_BR**:
  - `addr_sel`=0.
  - Condition `take`: BRANCH=1, BZERO=`cond_flags[0]`, BNZERO=!`cond_flags[0]`, BNEG=`cond_flags[1]`, BNNEG=!`cond_flags[1]`.
  - If `take`: `branch`=1 and `pc_enable`=1. Otherwise all enables are 0, and PC keeps the value already incremented in FETCH.
  - Next state: FETCH.
- **HALT**:
  - `halted`=1 and all enables 0.
  - Stays in HALT until reset; `decoded_instruction` is ignored.

## Timing
- Outputs are combinational from the current state and `decoded_instruction` (Mealy in the EXEC states only). No output glitches matter, since all consumers sample at `clk`.
- Instruction latency in cycles:
  - NOP or unknown encoding: 2.
  - All other instructions: 3.
  - HALT: 2 to reach HALT.
- Only one of `ir_enable`, `write_reg_enable`, `ram_write_enable` is high in any cycle.
- `pc_enable` is high only in FETCH, or in EXEC_BR when the branch is taken.
- A flag-setting instruction followed directly by a conditional branch uses that instruction's flags: the capture happens in the intervening FETCH.
- `rst_n` low in any state, including mid-EXEC or HALT, aborts the instruction. No RAM or register write occurs in that cycle, and the next state is FETCH.
- `decoded_instruction` must be stable from DECODE through EXEC. The IR changes only in FETCH.

## Test plan
- **Reset**: hold `rst_n`=0 for 2 cycles, then release. → All outputs are 0 during reset. The first cycle after release shows FETCH (`ir_enable`=`pc_enable`=`addr_sel`=1). `cond_flags`=0.
- **ADD**: drive ADD in DECODE. → The following cycle shows `operation`=01, `write_reg_enable`=1, `flags_reg_enable`=1, `c_sel`=0. With `zero_op`=1 in the next FETCH, `cond_flags`=4'b0001 afterwards.
- **BZERO after SUB**: SUB produces `zero_op`=1, then BZERO. → EXEC_BR asserts `branch`=1 and `pc_enable`=1. Repeat with `zero_op`=0. → `branch`=0, `pc_enable`=0.
- **MOVE does not touch flags**: SUB (neg=1), then MOVE, then BNEG. → `cond_flags[1]` stays 1 across MOVE. BNEG is taken. MOVE shows `flags_reg_enable`=0 and `operation`=00.
- **LOAD / STORE**:
  - LOAD → one cycle of `c_sel`=1, `write_reg_enable`=1, `addr_sel`=0.
  - STORE → one cycle of `ram_write_enable`=1, `addr_sel`=0, `write_reg_enable`=0.
  - Each returns to FETCH; each instruction takes 3 cycles.
- **HALT and abort**:
  - HALT → `halted`=1 stays for 10 cycles while `decoded_instruction` toggles.
  - Asserting `rst_n`=0 during HALT → FETCH follows. Likewise, reset asserted during EXEC_STORE → `ram_write_enable`=0 in that cycle.
